// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix UART printer: ASCII codes, FSM encoding
// and the decimal power table used by the digit converter.
package matrix_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [2:0] LAST_POW = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SIGN,
    ST_DIGIT,
    ST_SEP,
    ST_FIN
  } state_e;

  function automatic logic [16:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    pow10 = 17'd10000;
      3'd1:    pow10 = 17'd1000;
      3'd2:    pow10 = 17'd100;
      3'd3:    pow10 = 17'd10;
      default: pow10 = 17'd1;
    endcase
  endfunction

endpackage

// File: rtl/matrix_uart_printer_uart_byte_tx.sv
// 8N1 byte serializer: one start bit, eight data bits LSB first, one stop bit.
// Busy stays high until the stop bit has been held for a full bit period.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [CNT_W-1:0] baud_q;
  logic [3:0]       idx_q;
  logic [8:0]       shift_q;
  logic             busy_q;
  logic             tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      baud_q <= '0;
      idx_q  <= '0;
    end else if (!busy_q) begin
      if (i_start) begin
        busy_q <= 1'b1;
        tx_q   <= 1'b0;
        baud_q <= '0;
        idx_q  <= '0;
      end
    end else if (baud_q == CNT_W'(CLKS_PER_BIT - 1)) begin
      baud_q <= '0;
      // idx 9 is the stop bit; its period ending frees the serializer
      if (idx_q == 4'd9) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        idx_q <= idx_q + 4'd1;
        tx_q  <= shift_q[0];
      end
    end else begin
      baud_q <= baud_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!busy_q && i_start) begin
      shift_q <= {1'b1, i_data};
    end else if (busy_q && baud_q == CNT_W'(CLKS_PER_BIT - 1) && idx_q != 4'd9) begin
      shift_q <= {1'b1, shift_q[8:1]};
    end
  end

  assign o_busy = busy_q;
  assign o_tx   = tx_q;

endmodule

// File: rtl/matrix_uart_printer.sv
// Streams an M x N matrix of signed 16-bit values from storage over UART as
// decimal ASCII text, elements space separated and rows terminated by CR LF.
module matrix_uart_printer
  import matrix_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DIM_W        = 3,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [DIM_W-1:0]  i_m,
  input  logic [DIM_W-1:0]  i_n,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic              uart_tx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DIM_W-1:0]   m_q, m_d, n_q, n_d, r_q, r_d, c_q, c_d;
  logic               neg_q, neg_d;
  logic [16:0]        rem_q, rem_d;
  logic [2:0]         pow_idx_q, pow_idx_d;
  logic [3:0]         digit_q, digit_d;
  logic               started_q, started_d;
  logic               crlf_q, crlf_d;
  logic               done_q, done_d, err_q, err_d;
  logic               tx_start, tx_busy;
  logic [7:0]         tx_data;
  logic [16:0]        pw;
  logic signed [15:0] elem;
  logic               unused_hi;

  // 17-bit magnitude so that -32768 is representable
  function automatic logic [16:0] magnitude(input logic signed [15:0] v);
    logic signed [16:0] ext;
    ext = {v[15], v};
    return v[15] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  assign elem      = i_rd_data[15:0];
  assign unused_hi = ^i_rd_data[31:16];
  assign pw        = pow10(pow_idx_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    m_d       = m_q;
    n_d       = n_q;
    r_d       = r_q;
    c_d       = c_q;
    neg_d     = neg_q;
    rem_d     = rem_q;
    pow_idx_d = pow_idx_q;
    digit_d   = digit_q;
    started_d = started_q;
    crlf_d    = crlf_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_start  = 1'b0;
    tx_data   = ASCII_SPACE;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_m == '0 || i_n == '0) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            addr_d  = i_base_addr;
            m_d     = i_m;
            n_d     = i_n;
            r_d     = '0;
            c_d     = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        neg_d     = elem[15];
        rem_d     = magnitude(elem);
        pow_idx_d = '0;
        digit_d   = '0;
        started_d = 1'b0;
        state_d   = ST_SIGN;
      end
      ST_SIGN: begin
        if (!neg_q) begin
          state_d = ST_DIGIT;
        end else if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = ASCII_MINUS;
          state_d  = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        // repeated subtraction; once rem < power the digit is final
        if (rem_q >= pw) begin
          rem_d   = rem_q - pw;
          digit_d = digit_q + 4'd1;
        end else if (digit_q != 4'd0 || started_q || pow_idx_q == LAST_POW) begin
          if (!tx_busy) begin
            tx_start  = 1'b1;
            tx_data   = ASCII_ZERO + {4'd0, digit_q};
            started_d = 1'b1;
            digit_d   = '0;
            if (pow_idx_q == LAST_POW) state_d = ST_SEP;
            else pow_idx_d = pow_idx_q + 3'd1;
          end
        end else begin
          pow_idx_d = pow_idx_q + 3'd1;
        end
      end
      ST_SEP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          if (c_q != n_q - DIM_W'(1)) begin
            tx_data = ASCII_SPACE;
            c_d     = c_q + DIM_W'(1);
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end else if (!crlf_q) begin
            tx_data = ASCII_CR;
            crlf_d  = 1'b1;
          end else begin
            tx_data = ASCII_LF;
            crlf_d  = 1'b0;
            if (r_q == m_q - DIM_W'(1)) begin
              state_d = ST_FIN;
            end else begin
              r_d     = r_q + DIM_W'(1);
              c_d     = '0;
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_FIN: begin
        if (!tx_busy) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      r_q       <= '0;
      c_q       <= '0;
      pow_idx_q <= '0;
      started_q <= 1'b0;
      crlf_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      r_q       <= r_d;
      c_q       <= c_d;
      pow_idx_q <= pow_idx_d;
      started_q <= started_d;
      crlf_q    <= crlf_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    m_q     <= m_d;
    n_q     <= n_d;
    neg_q   <= neg_d;
    rem_q   <= rem_d;
    digit_q <= digit_d;
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_data (tx_data),
    .i_start(tx_start),
    .o_busy (tx_busy),
    .o_tx   (uart_tx)
  );

  assign o_rd_addr = addr_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Scoreboard bench: expected text is built from storage contents with
// $sformatf and compared against bytes decoded from the serial line.
module tb_matrix_uart_printer;

  localparam int CLKS   = 8;
  localparam int DIM_W  = 3;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic [ADDR_W-1:0] i_base_addr = '0;
  logic [DIM_W-1:0]  i_m = '0;
  logic [DIM_W-1:0]  i_n = '0;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [31:0]       i_rd_data;
  logic              uart_tx, o_busy, o_done, o_err;

  logic [31:0] mem [256];
  logic [7:0]  exp_q [$];
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, rx_cnt = 0, print_id = 0;

  matrix_uart_printer #(.CLKS_PER_BIT(CLKS), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_m(i_m), .i_n(i_n), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .uart_tx(uart_tx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_done) done_cnt <= done_cnt + 1;
    i_rd_data <= mem[o_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_matrix(input logic [7:0] base, input int m, input int n);
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        logic [7:0] a;
        logic signed [15:0] v;
        string s;
        a = 8'(int'(base) + r * n + c);
        v = mem[a][15:0];
        s = $sformatf("%0d", v);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        if (c < n - 1) exp_q.push_back(8'h20);
        else begin
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
        end
      end
    end
  endtask

  task automatic pulse_start(input logic [7:0] base, input int m, input int n);
    @(negedge clk);
    i_base_addr = base;
    i_m = DIM_W'(m);
    i_n = DIM_W'(n);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_print(input logic [7:0] base, input int m, input int n, input bit dbl);
    int d0, k;
    print_id++;
    expect_matrix(base, m, n);
    d0 = done_cnt;
    pulse_start(base, m, n);
    check("busy_after_start", o_busy, 1);
    if (dbl) begin
      repeat (200) @(negedge clk);
      pulse_start(base + 8'd40, 2, 2);
    end
    k = 0;
    while (o_done !== 1'b1 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", o_done, 1);
    check("err_clear", o_err, 0);
    check("busy_low_at_done", o_busy, 0);
    check("bytes_left", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    exp_q.delete();
  endtask

  // serial-line monitor: decode each frame and pop the scoreboard
  initial begin : monitor
    int prev_start, prev_id, s_cyc;
    logic [8:0] bits;
    bit ab;
    prev_start = 0;
    prev_id = -1;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        s_cyc = cyc;
        ab = 1'b0;
        check("busy_at_byte", o_busy, 1);
        repeat (CLKS / 2) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
        end
        for (int k = 0; k < 9; k++) begin
          repeat (CLKS) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
          end
          bits[k] = uart_tx;
        end
        if (!ab) begin
          check("stop_bit", bits[8], 1);
          if (exp_q.size() == 0) check("unexpected_byte", bits[7:0], 32'h100);
          else check("byte", bits[7:0], exp_q.pop_front());
          rx_cnt++;
          if (prev_id == print_id)
            check("gap_le_2", (s_cyc - prev_start - 10 * CLKS) <= 2, 1);
          prev_id = print_id;
          prev_start = s_cyc;
        end else begin
          prev_id = -1;
        end
      end
    end
  end

  initial begin : main
    logic [7:0] a0;
    int k, r0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_err", o_err, 0);
    check("reset_addr", o_rd_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) mem[i] = {16'h1234, 16'(i + 1)};
    run_print(8'd0, 2, 3, 1'b0);

    mem[12] = 32'hAAAA_0001; mem[13] = 32'h5555_0004; mem[14] = 32'h0000_0002;
    mem[15] = 32'hFFFF_0005; mem[16] = 32'h0F0F_0003; mem[17] = 32'h8000_0006;
    run_print(8'd12, 3, 2, 1'b0);

    mem[254] = 32'hFFFF_0000; mem[255] = 32'h0001_FECF;
    mem[0]   = 32'hDEAD_7FFF; mem[1]   = 32'h7777_8000;
    run_print(8'd254, 1, 4, 1'b0);

    a0 = o_rd_addr;
    r0 = rx_cnt;
    pulse_start(8'd99, 0, 3);
    check("zero_err", o_err, 1);
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 0);
    @(negedge clk);
    check("zero_err_pulse", o_err, 0);
    check("zero_done_pulse", o_done, 0);
    repeat (100) @(negedge clk);
    check("zero_no_read", o_rd_addr, a0);
    check("zero_no_bytes", rx_cnt - r0, 0);
    check("zero_tx_idle", uart_tx, 1);

    for (int i = 0; i < 6; i++) mem[i] = {16'h4321, 16'(i + 1)};
    run_print(8'd0, 2, 3, 1'b1);

    print_id++;
    expect_matrix(8'd0, 2, 3);
    r0 = rx_cnt;
    pulse_start(8'd0, 2, 3);
    k = 0;
    while (rx_cnt < r0 + 2 && k < 5000) begin @(negedge clk); k++; end
    check("rx_two_before_rst", rx_cnt - r0, 2);
    k = 0;
    while (uart_tx !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
    repeat (3 * CLKS) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx_high", uart_tx, 1);
    check("rst_busy_low", o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (12 * CLKS) @(negedge clk);
    run_print(8'd0, 2, 3, 1'b0);

    for (int t = 0; t < 5; t++) begin
      logic [7:0] base;
      int m, n;
      base = 8'($urandom_range(0, 255));
      m = $urandom_range(1, 3);
      n = $urandom_range(1, 3);
      for (int i = 0; i < m * n; i++) begin
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
          0: v[15:0] = 16'h8000;
          1: v[15:0] = 16'h0000;
          2: v[15:0] = 16'(v[3:0]);
          default: ;
        endcase
        mem[8'(int'(base) + i)] = v;
      end
      run_print(base, m, n, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
